// File: rtl/instr_cache_refill_unit_if.sv
// Signal bundle between the instruction-cache refill unit and its cache/memory
// neighbours; master is the refill unit, slave is the cache/memory side.
interface instr_cache_refill_unit_if #(
  parameter int ADDR_W = 32
);
  logic              ic_miss_i;
  logic [ADDR_W-1:0] miss_addr_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              ic_repl_grant_o;
  logic [63:0]       rep_word_o;
  logic              refill_busy_o;
  logic              refill_done_o;

  modport master (
    input  ic_miss_i, miss_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output mem_req_o, mem_addr_o, ic_repl_grant_o, rep_word_o,
           refill_busy_o, refill_done_o
  );

  modport slave (
    output ic_miss_i, miss_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  mem_req_o, mem_addr_o, ic_repl_grant_o, rep_word_o,
           refill_busy_o, refill_done_o
  );
endinterface

// File: rtl/instr_cache_refill_unit.sv
// Instruction-cache refill: fetches one block as 32-bit words from memory,
// then streams it to the cache sets as contiguous 64-bit beats.
module instr_cache_refill_unit #(
  parameter int B      = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              ic_repl_grant_o,
  output logic [63:0]       rep_word_o,
  output logic              refill_busy_o,
  output logic              refill_done_o
);

  localparam int WORDS = B / 4;
  localparam int BEATS = B / 8;
  localparam int IW    = $clog2(WORDS);
  localparam int CW    = IW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]     recv_cnt_q, recv_cnt_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       buffer_q [WORDS];
  logic              issue, capture;
  logic [IW-1:0]     lo_idx, hi_idx;

  assign issue   = mem_req_q && mem_gnt_i;
  assign capture = (state_q == FETCH) && mem_rvalid_i && (recv_cnt_q < CW'(WORDS));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ic_miss_i) begin
          base_d      = miss_addr_i & ~ADDR_W'(B - 1);
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          beat_cnt_d  = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (issue) issue_cnt_d = issue_cnt_q + 1'b1;
        if (capture) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == CW'(WORDS - 1)) begin
            beat_cnt_d = '0;
            state_d    = STREAM;
          end
        end
      end
      STREAM: begin
        if (beat_cnt_q == CW'(BEATS - 1)) begin
          beat_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they switch with the state flop.
  always_comb begin
    mem_req_d = (state_d == FETCH) && (issue_cnt_d < CW'(WORDS));
    grant_d   = (state_d == STREAM);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == STREAM) && (beat_cnt_d == CW'(BEATS - 1));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      mem_req_q   <= mem_req_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) buffer_q[recv_cnt_q[IW-1:0]] <= mem_rdata_i;
  end

  always_comb begin
    lo_idx = IW'({beat_cnt_q, 1'b0});
    hi_idx = lo_idx | IW'(1);
  end

  assign mem_req_o       = mem_req_q;
  assign mem_addr_o      = (state_q == FETCH) ? base_q + ADDR_W'({issue_cnt_q, 2'b00}) : base_q;
  assign ic_repl_grant_o = grant_q;
  assign rep_word_o      = grant_q ? {buffer_q[hi_idx], buffer_q[lo_idx]} : '0;
  assign refill_busy_o   = busy_q;
  assign refill_done_o   = done_q;

endmodule

// File: tb/tb_instr_cache_refill_unit.sv
// Directed bench for instr_cache_refill_unit: a small memory model answers
// requests with data = address; each task drives one scenario and checks it.
module tb_instr_cache_refill_unit;
  localparam int B      = 64;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_cache_refill_unit_if #(.ADDR_W(ADDR_W)) bus();

  instr_cache_refill_unit #(.B(B), .ADDR_W(ADDR_W)) dut (
    .clk_i           (clk),
    .reset_n_i       (rst_n),
    .ic_miss_i       (bus.ic_miss_i),
    .miss_addr_i     (bus.miss_addr_i),
    .mem_req_o       (bus.mem_req_o),
    .mem_addr_o      (bus.mem_addr_o),
    .mem_gnt_i       (bus.mem_gnt_i),
    .mem_rvalid_i    (bus.mem_rvalid_i),
    .mem_rdata_i     (bus.mem_rdata_i),
    .ic_repl_grant_o (bus.ic_repl_grant_o),
    .rep_word_o      (bus.rep_word_o),
    .refill_busy_o   (bus.refill_busy_o),
    .refill_done_o   (bus.refill_done_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // memory model state
  int cyc = 0, lat = 1, stall_at = -1, stall_left = 0;
  bit gaps = 0, gap_tog = 0, stray = 0;
  int n_req, req_first, req_last, rv_cnt, rv_last;
  logic [31:0] req_log[$], pend_a[$], stall_addr[$];
  int pend_t[$];

  // per-refill observations
  int g_cnt, done_cnt, done_idx, stream_start;
  logic busy_after;
  bit timed_out, fetch_ok;
  logic [63:0] beats [16];

  function automatic logic [63:0] exp_beat(input logic [31:0] base, input int k);
    return {base + 32'(8 * k + 4), base + 32'(8 * k)};
  endfunction

  task automatic clear_model();
    n_req = 0; req_first = -1; req_last = -1; rv_cnt = 0; rv_last = -1; gap_tog = 0;
    req_log.delete(); pend_a.delete(); pend_t.delete(); stall_addr.delete();
  endtask

  task automatic step();
    logic g, rv;
    logic [31:0] rd;
    @(negedge clk);
    cyc++;
    g = 1'b1;
    if (bus.mem_req_o === 1'b1 && n_req == stall_at && stall_left > 0) begin
      g = 1'b0; stall_left--; stall_addr.push_back(bus.mem_addr_o);
    end
    if (bus.mem_req_o === 1'b1 && g) begin
      req_log.push_back(bus.mem_addr_o); pend_a.push_back(bus.mem_addr_o); pend_t.push_back(cyc + lat);
      if (req_first < 0) req_first = cyc;
      req_last = cyc; n_req++;
    end
    rv = 1'b0; rd = '0;
    if (pend_a.size() > 0 && pend_t[0] <= cyc && !(gaps && gap_tog)) begin
      rv = 1'b1; rd = pend_a.pop_front(); void'(pend_t.pop_front()); rv_cnt++; rv_last = cyc;
    end else if (stray && pend_a.size() == 0 && bus.mem_req_o !== 1'b1) begin
      rv = 1'b1; rd = 32'hDEAD_BEEF;
    end
    gap_tog = ~gap_tog;
    bus.mem_gnt_i = g; bus.mem_rvalid_i = rv; bus.mem_rdata_i = rd;
  endtask

  // Raise a miss at the current negedge and follow the refill until the grant drops.
  task automatic run(input logic [31:0] a, input int miss_hold);
    logic prev_g;
    clear_model();
    g_cnt = 0; done_cnt = 0; done_idx = -1; stream_start = -1; busy_after = 1'bx;
    timed_out = 1; fetch_ok = 0; prev_g = 1'b0;
    bus.ic_miss_i = 1'b1; bus.miss_addr_i = a;
    for (int c = 0; c < 400; c++) begin
      step();
      if (c == 0)
        fetch_ok = (bus.mem_req_o === 1'b1) && (bus.refill_busy_o === 1'b1) &&
                   (bus.mem_addr_o === (a & ~32'(B - 1)));
      if (c == miss_hold - 1) bus.ic_miss_i = 1'b0;
      if (bus.ic_repl_grant_o === 1'b1) begin
        if (g_cnt == 0) stream_start = cyc;
        if (g_cnt < 16) beats[g_cnt] = bus.rep_word_o;
        if (bus.refill_done_o === 1'b1) begin done_cnt++; done_idx = g_cnt; end
        g_cnt++;
      end else if (bus.refill_done_o === 1'b1) begin
        done_cnt++;
      end
      if (prev_g && bus.ic_repl_grant_o !== 1'b1) begin
        busy_after = bus.refill_busy_o; timed_out = 0; break;
      end
      prev_g = (bus.ic_repl_grant_o === 1'b1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (bus.mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", bus.mem_req_o); end
    tests_run++; if (bus.mem_addr_o !== '0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr_o); end
    tests_run++; if (bus.ic_repl_grant_o !== 1'b0) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0", bus.ic_repl_grant_o); end
    tests_run++; if (bus.refill_busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.refill_busy_o); end
    tests_run++; if (bus.refill_done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.refill_done_o); end
    tests_run++; if (bus.rep_word_o !== '0) begin tests_failed++; $display("FAIL reset_rep: got %h expected 0", bus.rep_word_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run(32'h0000_1234, 1);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL basic_timeout: got no end of stream expected end within 400 cycles"); end
    tests_run++; if (!fetch_ok) begin tests_failed++; $display("FAIL basic_fetch_entry: got req=%b addr=%h expected req=1 addr=00001200", bus.mem_req_o, bus.mem_addr_o); end
    tests_run++; if (n_req !== 16) begin tests_failed++; $display("FAIL basic_nreq: got %0d expected 16", n_req); end
    tests_run++; if (req_last - req_first !== 15) begin tests_failed++; $display("FAIL basic_req_span: got %0d expected 15", req_last - req_first); end
    for (int i = 0; i < 16 && i < n_req; i++) begin
      tests_run++; if (req_log[i] !== 32'h1200 + 32'(4 * i)) begin tests_failed++; $display("FAIL basic_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'h1200 + 32'(4 * i)); end
    end
    tests_run++; if (g_cnt !== 8) begin tests_failed++; $display("FAIL basic_grant_len: got %0d expected 8", g_cnt); end
    for (int k = 0; k < 8; k++) begin
      tests_run++; if (beats[k] !== exp_beat(32'h1200, k)) begin tests_failed++; $display("FAIL basic_beat[%0d]: got %h expected %h", k, beats[k], exp_beat(32'h1200, k)); end
    end
    tests_run++; if (beats[0] !== 64'h0000_1204_0000_1200) begin tests_failed++; $display("FAIL basic_beat0_const: got %h expected 0000120400001200", beats[0]); end
    tests_run++; if (done_cnt !== 1 || done_idx !== 7) begin tests_failed++; $display("FAIL basic_done: got count=%0d beat=%0d expected count=1 beat=7", done_cnt, done_idx); end
    tests_run++; if (stream_start !== rv_last + 1) begin tests_failed++; $display("FAIL basic_stream_start: got %0d expected %0d", stream_start, rv_last + 1); end
    tests_run++; if (busy_after !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
    tests_run++; if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h1200) begin tests_failed++; $display("FAIL basic_idle_bus: got req=%b addr=%h expected req=0 addr=00001200", bus.mem_req_o, bus.mem_addr_o); end
  endtask

  task automatic test_gnt_stall();
    stall_at = 5; stall_left = 3;
    run(32'h0000_1234, 1);
    stall_at = -1;
    tests_run++; if (stall_addr.size() !== 3) begin tests_failed++; $display("FAIL stall_cycles: got %0d expected 3", stall_addr.size()); end
    foreach (stall_addr[i]) begin
      tests_run++; if (stall_addr[i] !== 32'h1214) begin tests_failed++; $display("FAIL stall_addr[%0d]: got %h expected 00001214", i, stall_addr[i]); end
    end
    tests_run++; if (n_req !== 16) begin tests_failed++; $display("FAIL stall_nreq: got %0d expected 16", n_req); end
    for (int i = 0; i < 16 && i < n_req; i++) begin
      tests_run++; if (req_log[i] !== 32'h1200 + 32'(4 * i)) begin tests_failed++; $display("FAIL stall_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'h1200 + 32'(4 * i)); end
    end
    tests_run++; if (req_last - req_first !== 18) begin tests_failed++; $display("FAIL stall_req_span: got %0d expected 18", req_last - req_first); end
    for (int k = 0; k < 8; k++) begin
      tests_run++; if (beats[k] !== exp_beat(32'h1200, k)) begin tests_failed++; $display("FAIL stall_beat[%0d]: got %h expected %h", k, beats[k], exp_beat(32'h1200, k)); end
    end
  endtask

  task automatic test_late_gaps();
    lat = 2; gaps = 1;
    run(32'h8000_0048, 1);
    lat = 1; gaps = 0;
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL late_timeout: got no end of stream expected end within 400 cycles"); end
    tests_run++; if (rv_cnt !== 16) begin tests_failed++; $display("FAIL late_rv_count: got %0d expected 16", rv_cnt); end
    tests_run++; if (stream_start !== rv_last + 1) begin tests_failed++; $display("FAIL late_stream_start: got %0d expected %0d", stream_start, rv_last + 1); end
    tests_run++; if (g_cnt !== 8) begin tests_failed++; $display("FAIL late_grant_len: got %0d expected 8", g_cnt); end
    for (int k = 0; k < 8; k++) begin
      tests_run++; if (beats[k] !== exp_beat(32'h8000_0040, k)) begin tests_failed++; $display("FAIL late_beat[%0d]: got %h expected %h", k, beats[k], exp_beat(32'h8000_0040, k)); end
    end
    tests_run++; if (done_idx !== 7) begin tests_failed++; $display("FAIL late_done_beat: got %0d expected 7", done_idx); end
  endtask

  task automatic test_back_to_back();
    run(32'h0000_2000, 5);
    tests_run++; if (timed_out || g_cnt !== 8 || done_cnt !== 1) begin tests_failed++; $display("FAIL drop_complete: got grants=%0d done=%0d expected grants=8 done=1", g_cnt, done_cnt); end
    tests_run++; if (beats[7] !== exp_beat(32'h2000, 7)) begin tests_failed++; $display("FAIL drop_beat7: got %h expected %h", beats[7], exp_beat(32'h2000, 7)); end
    run(32'h0000_3010, 1);
    tests_run++; if (!fetch_ok) begin tests_failed++; $display("FAIL b2b_fetch_entry: got req=%b busy=%b expected req=1 busy=1", bus.mem_req_o, bus.refill_busy_o); end
    tests_run++; if (g_cnt !== 8) begin tests_failed++; $display("FAIL b2b_grant_len: got %0d expected 8", g_cnt); end
    tests_run++; if (beats[0] !== 64'h0000_3004_0000_3000) begin tests_failed++; $display("FAIL b2b_beat0: got %h expected 0000300400003000", beats[0]); end
  endtask

  task automatic test_reset_mid_stream();
    int g;
    bit found;
    clear_model();
    g = 0; found = 0;
    bus.ic_miss_i = 1'b1; bus.miss_addr_i = 32'h0000_4444;
    for (int c = 0; c < 200; c++) begin
      step();
      if (c == 0) bus.ic_miss_i = 1'b0;
      if (bus.ic_repl_grant_o === 1'b1) begin
        if (g == 3) begin found = 1; break; end
        g++;
      end
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL rst_reach_beat3: got %0d grant cycles expected beat 3", g); end
    tests_run++; if (bus.rep_word_o !== exp_beat(32'h4440, 3)) begin tests_failed++; $display("FAIL rst_beat3: got %h expected %h", bus.rep_word_o, exp_beat(32'h4440, 3)); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.ic_repl_grant_o !== 1'b0) begin tests_failed++; $display("FAIL rst_async_grant: got %b expected 0", bus.ic_repl_grant_o); end
    tests_run++; if (bus.refill_busy_o !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b expected 0", bus.refill_busy_o); end
    tests_run++; if (bus.rep_word_o !== '0 || bus.refill_done_o !== 1'b0) begin tests_failed++; $display("FAIL rst_async_rep: got rep=%h done=%b expected rep=0 done=0", bus.rep_word_o, bus.refill_done_o); end
    tests_run++; if (bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== '0) begin tests_failed++; $display("FAIL rst_async_bus: got req=%b addr=%h expected req=0 addr=0", bus.mem_req_o, bus.mem_addr_o); end
    #1 rst_n = 1'b1;
    run(32'h0000_1234, 1);
    tests_run++; if (n_req !== 16 || req_log[0] !== 32'h1200) begin tests_failed++; $display("FAIL rst_restart: got nreq=%0d first=%h expected nreq=16 first=00001200", n_req, (n_req > 0) ? req_log[0] : 32'hx); end
    tests_run++; if (g_cnt !== 8 || beats[0] !== exp_beat(32'h1200, 0)) begin tests_failed++; $display("FAIL rst_restart_stream: got grants=%0d beat0=%h expected grants=8 beat0=%h", g_cnt, beats[0], exp_beat(32'h1200, 0)); end
  endtask

  task automatic test_stray_rvalid();
    stray = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++; if (bus.refill_busy_o !== 1'b0 || bus.ic_repl_grant_o !== 1'b0) begin tests_failed++; $display("FAIL stray_idle_state[%0d]: got busy=%b grant=%b expected busy=0 grant=0", i, bus.refill_busy_o, bus.ic_repl_grant_o); end
      tests_run++; if (bus.rep_word_o !== '0 || bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h1200) begin tests_failed++; $display("FAIL stray_idle_out[%0d]: got rep=%h req=%b addr=%h expected rep=0 req=0 addr=00001200", i, bus.rep_word_o, bus.mem_req_o, bus.mem_addr_o); end
    end
    run(32'h0000_5500, 1);
    stray = 0;
    tests_run++; if (g_cnt !== 8) begin tests_failed++; $display("FAIL stray_grant_len: got %0d expected 8", g_cnt); end
    for (int k = 0; k < 8; k++) begin
      tests_run++; if (beats[k] !== exp_beat(32'h5500, k)) begin tests_failed++; $display("FAIL stray_beat[%0d]: got %h expected %h", k, beats[k], exp_beat(32'h5500, k)); end
    end
  endtask

  initial begin
    bus.ic_miss_i = 1'b0; bus.miss_addr_i = '0; bus.mem_gnt_i = 1'b1;
    bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    clear_model();
    test_reset();
    test_basic();
    test_gnt_stall();
    test_late_gaps();
    test_back_to_back();
    test_reset_mid_stream();
    test_stray_rvalid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
